// File: rtl/brightness_pkg.sv
`default_nettype none
// ============================================================================
// brightness_pkg : shared widths, limits and FSM states for brightness_ramp_ctrl
// Revision 1.0
// ============================================================================
package brightness_pkg;

  localparam int BRIGHT_W = 4;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 4'd15;

  typedef enum logic [2:0] {
    MANUAL  = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/rise_edge_det.sv
`default_nettype none
// ============================================================================
// rise_edge_det : one-cycle pulse on a 0->1 transition of a synchronised level
// Revision 1.0
// ============================================================================
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Delay register keeps tracking the input regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule
`default_nettype wire

// File: rtl/brightness_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// brightness_ramp_ctrl : manual / auto-fade brightness operand for the shader
// Revision 1.0
// ============================================================================
module brightness_ramp_ctrl
  import brightness_pkg::*;
#(
  parameter int STEP_DIV   = 1_000_000,
  parameter int HOLD_STEPS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode,
  input  logic                btn_up,
  input  logic                btn_down,
  output logic [BRIGHT_W-1:0] bright,
  output logic                ramping,
  output logic                step_tick
);

  localparam int PRESC_W = $clog2(STEP_DIV);
  localparam int HOLD_W  = $clog2(HOLD_STEPS) + 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_STEPS - 1);

  ramp_state_t          state;
  logic [PRESC_W-1:0]   presc;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 up_rise;
  logic                 down_rise;
  logic                 up_ev;
  logic                 down_ev;

  rise_edge_det u_up_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_up),
    .rise  (up_rise)
  );

  rise_edge_det u_down_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_down),
    .rise  (down_rise)
  );

  assign up_ev     = up_rise & ~down_rise;
  assign down_ev   = down_rise & ~up_rise;
  assign step_tick = enable && (state != MANUAL) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MANUAL;
      ramping  <= 1'b0;
      bright   <= '0;
      presc    <= '0;
      hold_cnt <= '0;
    end else if (!enable) begin
      presc <= '0;
    end else if (state == MANUAL) begin
      if (mode) begin
        state   <= RISE;
        ramping <= 1'b1;
        presc   <= '0;
      end else if (up_ev && bright != BRIGHT_MAX) begin
        bright <= bright + 1'b1;
      end else if (down_ev && bright != '0) begin
        bright <= bright - 1'b1;
      end
    end else if (!mode) begin
      state    <= MANUAL;
      ramping  <= 1'b0;
      presc    <= '0;
      hold_cnt <= '0;
    end else begin
      presc <= step_tick ? '0 : presc + 1'b1;
      if (step_tick) begin
        // Each ramp spends one extra step at the extreme before handing over.
        case (state)
          RISE: begin
            if (bright == BRIGHT_MAX) begin
              state    <= HOLD_HI;
              ramping  <= 1'b0;
              hold_cnt <= '0;
            end else begin
              bright <= bright + 1'b1;
            end
          end
          HOLD_HI: begin
            if (hold_cnt == HOLD_LAST) begin
              state   <= FALL;
              ramping <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          FALL: begin
            if (bright == '0) begin
              state    <= HOLD_LO;
              ramping  <= 1'b0;
              hold_cnt <= '0;
            end else begin
              bright <= bright - 1'b1;
            end
          end
          HOLD_LO: begin
            if (hold_cnt == HOLD_LAST) begin
              state   <= RISE;
              ramping <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            state   <= MANUAL;
            ramping <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_brightness_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_brightness_ramp_ctrl : directed stimulus, per-cycle model compare plus
// hand-computed literal expectations. Revision 1.0
// ============================================================================
module tb_brightness_ramp_ctrl;

  localparam int STEP_DIV   = 4;
  localparam int HOLD_STEPS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] bright;
  logic       ramping;
  logic       step_tick;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  brightness_ramp_ctrl #(
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .bright    (bright),
    .ramping   (ramping),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  // Model: auto flag, phase 0=rise 1=hold-high 2=fall 3=hold-low, cycles into current step.
  int m_bright = 0;
  bit m_auto   = 0;
  int m_phase  = 0;
  int m_holds  = 0;
  int m_cyc    = 0;
  bit m_pu     = 0;
  bit m_pd     = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bright = 0; m_auto = 0; m_phase = 0; m_holds = 0; m_cyc = 0; m_pu = 0; m_pd = 0;
    end else begin
      bit up, dn, tk;
      up = btn_up && !m_pu;
      dn = btn_down && !m_pd;
      m_pu = btn_up;
      m_pd = btn_down;
      if (!enable) begin
        m_cyc = 0;
      end else if (!m_auto) begin
        if (mode) begin
          m_auto = 1; m_phase = 0; m_cyc = 0;
        end else if (up && !dn) begin
          m_bright = (m_bright < 15) ? m_bright + 1 : 15;
        end else if (dn && !up) begin
          m_bright = (m_bright > 0) ? m_bright - 1 : 0;
        end
      end else if (!mode) begin
        m_auto = 0; m_cyc = 0; m_holds = 0;
      end else begin
        tk = (m_cyc == STEP_DIV - 1);
        m_cyc = tk ? 0 : m_cyc + 1;
        if (tk) begin
          if (m_phase == 0) begin
            if (m_bright == 15) begin m_phase = 1; m_holds = 0; end
            else m_bright++;
          end else if (m_phase == 2) begin
            if (m_bright == 0) begin m_phase = 3; m_holds = 0; end
            else m_bright--;
          end else if (m_holds == HOLD_STEPS - 1) begin
            m_phase = (m_phase + 1) % 4;
          end else begin
            m_holds++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      bit exp_ramp, exp_tick;
      exp_ramp = m_auto && (m_phase == 0 || m_phase == 2);
      exp_tick = m_auto && enable && rst_n && (m_cyc == STEP_DIV - 1);
      checks++;
      if (bright !== 4'(m_bright) || ramping !== exp_ramp || step_tick !== exp_tick) begin
        errors++;
        $display("FAIL model t=%0t bright=%0d/%0d ramping=%0b/%0b step_tick=%0b/%0b (got/exp)",
                 $time, bright, m_bright, ramping, exp_ramp, step_tick, exp_tick);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_up();
    btn_up = 1'b1; step();
    btn_up = 1'b0; step();
  endtask

  task automatic pulse_down();
    btn_down = 1'b1; step();
    btn_down = 1'b0; step();
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_bright", int'(bright), 0);
    chk("reset_ramping", int'(ramping), 0);
    chk("reset_tick", int'(step_tick), 0);
    step(2);
    go = 1'b1;
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    for (int i = 1; i <= 17; i++) begin
      pulse_up();
      if (i == 1 || i == 15 || i == 17) chk($sformatf("up_pulse_%0d", i), int'(bright), (i > 15) ? 15 : i);
    end
    for (int i = 1; i <= 17; i++) pulse_down();
    chk("down_floor", int'(bright), 0);

    repeat (3) pulse_up();
    btn_up = 1'b1; btn_down = 1'b1; step();
    btn_up = 1'b0; btn_down = 1'b0; step();
    chk("both_edges", int'(bright), 3);
    btn_up = 1'b1; step(10);
    btn_up = 1'b0; step();
    chk("held_level", int'(bright), 4);
    repeat (4) pulse_down();

    // Auto fade from 0; edge E0 is the one that samples mode=1.
    mode = 1'b1; step();
    chk("auto_enter_ramping", int'(ramping), 1);
    step(3);
    chk("first_tick_E3", int'(step_tick), 1);
    step(57);
    chk("bright15_E60", int'(bright), 15);
    chk("ramping_E60", int'(ramping), 1);
    step(4);
    chk("hold_hi_E64", int'(ramping), 0);
    step(8);
    chk("fall_E72", int'(ramping), 1);
    step(60);
    chk("bright0_E132", int'(bright), 0);
    step(12);
    chk("rise_again_E144", int'(ramping), 1);

    // Second lap: FALL reaches 9 at E240.
    step(96);
    chk("fall_at_9", int'(bright), 9);
    enable = 1'b0; step(20);
    chk("frozen_9", int'(bright), 9);
    enable = 1'b1; step(3);
    chk("no_early_dec", int'(bright), 9);
    step();
    chk("dec_after_4", int'(bright), 8);

    // bright reaches 6 in RISE at E332.
    step(68);
    chk("rise_at_6", int'(bright), 6);
    chk("rise_at_6_ramping", int'(ramping), 1);
    mode = 1'b0; step();
    chk("manual_exit_bright", int'(bright), 6);
    chk("manual_exit_ramping", int'(ramping), 0);
    pulse_up();
    chk("manual_after_auto", int'(bright), 7);

    mode = 1'b1; step(3);
    chk("pre_reset_bright", int'(bright), 7);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_bright", int'(bright), 0);
    chk("async_reset_ramping", int'(ramping), 0);
    mode = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_reset_bright", int'(bright), 0);

    go = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/brightness_ramp_ctrl.md
# brightness_ramp_ctrl

Sequential controller that produces the 4-bit `bright` operand consumed by the pixel shader stage, which adds it with saturation to each colour channel. It runs in manual mode, stepping on up/down button edges, or in auto mode, fading up, holding, fading down and holding in a loop. A programmable prescaler sets the fade rate. It sits directly upstream of the shader and drives its brightness input straight from a register.

## Interface
- `STEP_DIV`, 1_000_000: clock cycles per brightness step in auto mode (≥ 2).
- `HOLD_STEPS`, 8: steps spent at each extreme in auto mode (≥ 1).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  1 = run; 0 = freeze all state.
- `mode`  in  1  0 = manual, 1 = auto fade.
- `btn_up`  in  1  already-synchronised level; rising edge = +1.
- `btn_down`  in  1  already-synchronised level; rising edge = −1.
- `bright`  out  4  brightness to shader, registered.
- `ramping`  out  1  1 while in RISE or FALL.
- `step_tick`  out  1  one-cycle pulse when the prescaler expires.

## Operation
- States: MANUAL, RISE, HOLD_HI, FALL, HOLD_LO.
- Edge detect: `up_ev = btn_up & ~btn_up_q` (same for down). `*_q` registers update every cycle, including while `enable`=0.
- MANUAL:
  - `up_ev` only: `bright` += 1, saturating at 15.
  - `down_ev` only: `bright` −= 1, saturating at 0.
  - Both in the same cycle: no change.
- Auto mode ignores buttons. All actions below occur only on a cycle with `step_tick`=1.
  - RISE: if `bright`=15, go to HOLD_HI and clear `hold_cnt`; else `bright`+1.
  - HOLD_HI: if `hold_cnt`=HOLD_STEPS−1, go to FALL; else `hold_cnt`+1.
  - FALL: if `bright`=0, go to HOLD_LO and clear `hold_cnt`; else `bright`−1.
  - HOLD_LO: if `hold_cnt`=HOLD_STEPS−1, go to RISE; else `hold_cnt`+1.
- `mode` 0→1 (sampled in MANUAL): go to RISE starting from the current `bright`; prescaler cleared.
- `mode` 1→0 in any auto state: go to MANUAL next edge; `bright` held; prescaler and `hold_cnt` cleared.
- `enable`=0:
  - state, `bright` and `hold_cnt` frozen;
  - prescaler cleared;
  - `step_tick`=0;
  - button events discarded.
- Arithmetic: `bright` is 4-bit unsigned and never wraps. `hold_cnt` width = clog2(HOLD_STEPS)+1. Prescaler width = clog2(STEP_DIV).

## Timing
- Reset values, applied asynchronously:
  - `bright`=0, state=MANUAL, `step_tick`=0, `ramping`=0;
  - prescaler=0, `hold_cnt`=0, `btn_*_q`=0.
- Reset deassertion mid-fade restarts in MANUAL with `bright`=0.
- Manual latency: the button is sampled high at edge N with `btn_q` low, so `bright` changes at edge N and is visible after it.
- Prescaler:
  - counts 0..STEP_DIV−1 while `enable`=1 and state≠MANUAL;
  - `step_tick`=1 combinationally while count=STEP_DIV−1; the count wraps to 0 on that edge;
  - after entering auto, the first tick is on the STEP_DIV-th cycle.
- Auto updates land on the edge where `step_tick`=1.
- Full auto period = (16 + HOLD_STEPS + 16 + HOLD_STEPS)·STEP_DIV cycles: each ramp takes 15 steps plus one exit step.
- `ramping` is a registered decode of the state, updated on the same edge as the state.

## Structure
- Package `brightness_pkg`:
  - `BRIGHT_W`=4;
  - `BRIGHT_MAX`=4'd15;
  - enum `ramp_state_t` {MANUAL, RISE, HOLD_HI, FALL, HOLD_LO}.
- Sub-module `rise_edge_det`: registered delay plus AND-NOT. Instantiated twice, once each for `btn_up` and `btn_down`.
- Top holds the FSM, prescaler and `hold_cnt`. Target size is about 150–250 lines total.

## Test plan
Benches use STEP_DIV=4 and HOLD_STEPS=2.
- Reset → `bright`=0, `ramping`=0, `step_tick`=0. Assert `rst_n`=0 mid-RISE at `bright`=7 → immediately `bright`=0, MANUAL.
- Manual:
  - 17 `btn_up` pulses → `bright` goes 1..15, then stays 15;
  - 17 `btn_down` pulses → reaches 0 and stays;
  - `btn_up` and `btn_down` rise together → unchanged;
  - holding a level high for 10 cycles → only +1.
- `mode`=1 from `bright`=0:
  - `step_tick` every 4 cycles;
  - `bright`=15 after 60 cycles, `ramping`=1 throughout;
  - HOLD_HI entered at 64;
  - FALL begins at 72;
  - `bright`=0 at 132;
  - RISE again at 144.
- `enable`=0 for 20 cycles at `bright`=9 in FALL → `bright` stays 9 and no ticks. After re-enable, the next decrement comes 4 cycles later.
- `mode` 1→0 at `bright`=6 in RISE → MANUAL with `bright`=6 and `ramping`=0. A later `btn_up` → 7.
